// File: rtl/serial_bit_sequencer_if.sv
// Handshake bundle for serial_bit_sequencer.
// master: the framing controller that requests runs.
// slave:  the sequencer itself.
interface serial_bit_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 4
);
  logic                 start;
  logic [CNT_WIDTH-1:0] len_in;
  logic                 hold;
  logic                 abort;
  logic [CNT_WIDTH-1:0] count_out;
  logic                 busy;
  logic                 shift_en;
  logic                 last_bit;
  logic                 done;

  modport master (
    output start, len_in, hold, abort,
    input  count_out, busy, shift_en, last_bit, done
  );

  modport slave (
    input  start, len_in, hold, abort,
    output count_out, busy, shift_en, last_bit, done
  );
endinterface

// File: rtl/serial_bit_sequencer.sv
// Loadable down-counting bit sequencer that frames serial adder operations.
// It runs a start/busy/done handshake. It supports hold (pause) and
// abort (cancel). It emits one shift_en per bit and flags the last bit.
// Optional build macro SERIAL_SEQ_WRAP_EN: continuous mode. At the end
// of a frame the counter reloads with the captured length. done pulses
// on the first bit of the next frame, and runs continue until abort or
// reset.
module serial_bit_sequencer #(
  parameter int unsigned CNT_WIDTH   = 4,
  parameter int unsigned DEFAULT_LEN = 8
) (
  input  logic                 i_clk,
  input  logic                 reset,
  serial_bit_sequencer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LP_DEFAULT_LEN = CNT_WIDTH'(DEFAULT_LEN);
  localparam logic [CNT_WIDTH-1:0] LP_ONE         = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] w_load_len;
`ifdef SERIAL_SEQ_WRAP_EN
  // The run length is needed only when frames repeat.
  logic [CNT_WIDTH-1:0] r_len;
`endif

  // A zero length request selects the default run length.
  always_comb begin
    w_load_len = (bus.len_in == '0) ? LP_DEFAULT_LEN : bus.len_in;
  end

  // Sequencer FSM. The priority order is reset, then abort, then start
  // or count.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_SEQ_WRAP_EN
      r_len   <= LP_DEFAULT_LEN;
`endif
    end else if (bus.abort) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        // IDLE and DONE load a run in the same way. Without a start,
        // DONE falls back to IDLE, which is a no-op when already idle.
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
`ifdef SERIAL_SEQ_WRAP_EN
            r_len   <= w_load_len;
`endif
            r_count <= w_load_len;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_done <= 1'b0;
          if (!bus.hold) begin
            if (r_count > LP_ONE) begin
              r_count <= r_count - LP_ONE;
            end else begin
`ifdef SERIAL_SEQ_WRAP_EN
              r_count <= r_len;
              r_done  <= 1'b1;
`else
              r_count <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping. shift_en and last_bit follow the current state and hold.
  always_comb begin
    bus.count_out = r_count;
    bus.busy      = r_busy;
    bus.done      = r_done;
    bus.shift_en  = (r_state == S_RUN) & ~bus.hold;
    bus.last_bit  = (r_state == S_RUN) & (r_count == LP_ONE);
  end

endmodule

// File: tb/tb_serial_bit_sequencer.sv
// Self-checking bench for serial_bit_sequencer. The expected outputs in
// the vector table come from hand-derived timing. The latency runs use
// random hold patterns. Define SERIAL_SEQ_WRAP_EN for both the DUT and
// this bench to exercise continuous mode.
module tb_serial_bit_sequencer;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_bit_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  serial_bit_sequencer #(
    .CNT_WIDTH  (CW),
    .DEFAULT_LEN(8)
  ) dut (
    .i_clk(clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic          chk;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          hold;
    logic          abort;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          shift;
    logic          last;
    logic          done;
  } vec_t;

  vec_t          tbl[$];
  logic [CW+3:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic void add(int chk, int rst, int start, int len, int hold, int abort,
                              int cnt, int busy, int shift, int last, int done);
    vec_t v;
    v.chk   = (chk != 0);
    v.rst   = (rst != 0);
    v.start = (start != 0);
    v.len   = CW'(len);
    v.hold  = (hold != 0);
    v.abort = (abort != 0);
    v.cnt   = CW'(cnt);
    v.busy  = (busy != 0);
    v.shift = (shift != 0);
    v.last  = (last != 0);
    v.done  = (done != 0);
    tbl.push_back(v);
  endfunction

  // An idle-cycle row: all outputs are zero.
  function automatic void idle(int start, int len, int abort);
    add(1, 0, start, len, 0, abort, 0, 0, 0, 0, 0);
  endfunction

  // Start a run, apply random holds and measure the latency to done.
  task automatic run_len(input int unsigned len_sel);
    int unsigned L, cyc, shifts, holds;
    bit seen;
    L = (len_sel == 0) ? 8 : len_sel;
    @(negedge clk);
    bus.start = 1'b1; bus.len_in = CW'(len_sel); bus.hold = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0; shifts = 0; holds = 0; seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      bus.hold = ($urandom_range(0, 2) == 0);
      #1;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        cyc++;
        if (bus.shift_en) shifts++;
        if (bus.hold && bus.busy) holds++;
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL lat_timeout len=%0d: done never seen, required within 64 cycles", L);
    end
    checks++;
    if (cyc != L + holds) begin
      errors++;
      $display("FAIL lat_cycles len=%0d: got %0d run cycles, required %0d", L, cyc, L + holds);
    end
    checks++;
    if (shifts != L) begin
      errors++;
      $display("FAIL lat_shifts len=%0d: got %0d shifts, required %0d", L, shifts, L);
    end
    bus.hold = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.count_out !== '0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL post_abort len=%0d: got busy=%b cnt=%0d done=%b, required 0 0 0",
               L, bus.busy, bus.count_out, bus.done);
    end
  endtask

  initial begin
    logic [CW+3:0] exp_v, act_v;
    reset = 1'b1;
    bus.start = 1'b0; bus.len_in = '0; bus.hold = 1'b0; bus.abort = 1'b0;

    // Reset held for 2 cycles. The first row is unchecked.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SERIAL_SEQ_WRAP_EN
    // Continuous mode with len 4: done coincides with each reload.
    idle(1, 4, 0);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++)
        add(1, 0, 0, 0, 0, 0, 4 - i, 1, 1, (i == 3) ? 1 : 0, (f > 0 && i == 0) ? 1 : 0);
    add(1, 0, 0, 0, 0, 1, 4, 1, 1, 0, 1);
    idle(0, 0, 0);
    idle(0, 0, 0);
`else
    // Default length (len_in = 0 selects 8).
    idle(1, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 0, 0, 8 - i, 1, 1, (i == 7) ? 1 : 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0);
    // len 3 with 2 hold cycles at count 2.
    idle(1, 3, 0);
    add(1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0);
    // len 1 with hold on the last bit.
    idle(1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0);
    // Start held while busy is ignored; abort at count 5 wins over start.
    idle(1, 0, 0);
    add(1, 0, 1, 9, 0, 0, 8, 1, 1, 0, 0);
    add(1, 0, 1, 9, 0, 0, 7, 1, 1, 0, 0);
    add(1, 0, 1, 9, 0, 0, 6, 1, 1, 0, 0);
    add(1, 0, 1, 9, 0, 1, 5, 1, 1, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    // Back-to-back: start in the DONE cycle with len 2.
    idle(1, 2, 0);
    add(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0);
    // Maximum length of 15.
    idle(1, 15, 0);
    for (int i = 0; i < 15; i++) add(1, 0, 0, 0, 0, 0, 15 - i, 1, 1, (i == 14) ? 1 : 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0);
    // Abort in DONE beats a start; reset mid-run clears everything.
    idle(1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 1, 4, 0, 1, 0, 0, 0, 0, 1);
    idle(0, 0, 0);
    idle(0, 0, 0);
    idle(1, 5, 0);
    add(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    idle(0, 0, 0);
`endif

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      reset      = tbl[k].rst;
      bus.start  = tbl[k].start;
      bus.len_in = tbl[k].len;
      bus.hold   = tbl[k].hold;
      bus.abort  = tbl[k].abort;
      if (tbl[k].chk)
        exp_q.push_back({tbl[k].cnt, tbl[k].busy, tbl[k].shift, tbl[k].last, tbl[k].done});
      #1;
      if (tbl[k].chk) begin
        exp_v = exp_q.pop_front();
        act_v = {bus.count_out, bus.busy, bus.shift_en, bus.last_bit, bus.done};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL vec%0d: got cnt=%0d busy=%b shift=%b last=%b done=%b, required cnt=%0d busy=%b shift=%b last=%b done=%b",
                   k, act_v[CW+3:4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[CW+3:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end

    reset = 1'b0;
    bus.start = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
    run_len(0);
    run_len(1);
    run_len(3);
    run_len(7);
    run_len(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
